// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor controller: opcodes,
// controller state encoding and instruction field positions.
package coproc_pkg;

    localparam logic [3:0] OP_READ   = 4'd1;
    localparam logic [3:0] OP_WRITE  = 4'd2;
    localparam logic [3:0] OP_SUM    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_MUL    = 4'd5;
    localparam logic [3:0] OP_TRANSP = 4'd6;
    localparam logic [3:0] OP_OPST   = 4'd7;
    localparam logic [3:0] OP_MULSCL = 4'd8;
    localparam logic [3:0] OP_DET2   = 4'd9;
    localparam logic [3:0] OP_DET3   = 4'd10;
    localparam logic [3:0] OP_DET4   = 4'd11;
    localparam logic [3:0] OP_DET5   = 4'd12;

    // Instruction layout: opcode, then address, then immediate data.
    localparam int OP_LSB   = 0;
    localparam int OP_W     = 4;
    localparam int ADDR_LSB = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_MEM_ACC,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_STORE_C,
        ST_FINISH
    } state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_SUM) && (op <= OP_DET5);
    endfunction

    // Determinant ops produce a scalar, so only one result word is stored.
    function automatic logic is_det(input logic [3:0] op);
        return (op >= OP_DET2) && (op <= OP_DET5);
    endfunction

endpackage

// File: rtl/coproc_mem_seq.sv
// Burst memory sequencer: walks base..base+count-1 one word per ack,
// inserting a one-cycle request gap after every ack.
module coproc_mem_seq #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic              dir_we,
    input  logic              ack,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              word_valid,
    output logic [CNT_W-1:0]  idx,
    output logic              last
);

    logic              active;
    logic              gap;
    logic              we_r;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  idx_r;

    assign req        = active & ~gap;
    assign addr       = base_r + ADDR_W'(idx_r);
    assign we         = active & we_r;
    assign idx        = idx_r;
    assign word_valid = req & ack;
    assign last       = (idx_r == count_r - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            gap     <= 1'b0;
            we_r    <= 1'b0;
            base_r  <= '0;
            count_r <= '0;
            idx_r   <= '0;
        end else if (start) begin
            // A burst launched on the final ack of the previous one still owes the gap.
            active  <= 1'b1;
            gap     <= word_valid;
            we_r    <= dir_we;
            base_r  <= base;
            count_r <= count;
            idx_r   <= '0;
        end else if (word_valid) begin
            if (last) begin
                active <= 1'b0;
                idx_r  <= '0;
            end else begin
                idx_r <= idx_r + 1'b1;
                gap   <= 1'b1;
            end
        end else if (gap) begin
            gap <= 1'b0;
        end
    end

endmodule

// File: rtl/coproc_ctrl.sv
// Matrix coprocessor control unit: instruction handshake, decode, single
// memory accesses and the load-A / load-B / execute / store-C sequence.
module coproc_ctrl
    import coproc_pkg::*;
#(
    parameter int              INSTR_W  = 32,
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 16,
    parameter int              MAT_N    = 5,
    parameter int              ELEM_W   = 8,
    parameter logic [ADDR_W-1:0] A_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] B_BASE = 8'h10,
    parameter logic [ADDR_W-1:0] C_BASE = 8'h20,
    localparam int             MAT_BITS = MAT_N * MAT_N * ELEM_W,
    localparam int             WORDS    = (MAT_BITS + DATA_W - 1) / DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rd_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [3:0]          alu_op,
    output logic                alu_start,
    input  logic                alu_done,
    output logic [MAT_BITS-1:0] mat_a,
    output logic [MAT_BITS-1:0] mat_b,
    input  logic [MAT_BITS-1:0] mat_c
);

    localparam int CNT_W    = $clog2(WORDS + 1);
    localparam int DATA_LSB = ADDR_LSB + ADDR_W;

    state_t state;
    state_t state_nx;

    logic [3:0]          op_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   imm_r;
    logic [DATA_W-1:0]   rd_r;
    logic [MAT_BITS-1:0] a_buf;
    logic [MAT_BITS-1:0] b_buf;
    logic [MAT_BITS-1:0] c_buf;
    logic [WORDS*DATA_W-1:0] c_pad;
    logic                alu_done_q;
    logic                alu_rise;

    logic              seq_start;
    logic [ADDR_W-1:0] seq_base;
    logic [CNT_W-1:0]  seq_count;
    logic              seq_dir_we;
    logic              word_valid;
    logic              seq_last;
    logic [CNT_W-1:0]  seq_idx;
    logic              word_end;

    coproc_mem_seq #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_mem_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (seq_start),
        .base       (seq_base),
        .count      (seq_count),
        .dir_we     (seq_dir_we),
        .ack        (mem_ack),
        .req        (mem_req),
        .addr       (mem_addr),
        .we         (mem_we),
        .word_valid (word_valid),
        .idx        (seq_idx),
        .last       (seq_last)
    );

    assign word_end    = word_valid & seq_last;
    assign alu_rise    = alu_done & ~alu_done_q;
    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_FINISH);
    assign alu_start   = (state == ST_EXEC);
    assign alu_op      = op_r;
    assign rd_data     = rd_r;
    assign mat_a       = a_buf;
    assign mat_b       = b_buf;

    // Result buffer zero-padded up to a whole number of memory words.
    always_comb begin
        c_pad                 = '0;
        c_pad[MAT_BITS-1:0]   = c_buf;
    end

    always_comb begin
        mem_wdata = '0;
        if (state == ST_STORE_C)
            mem_wdata = c_pad[int'(seq_idx)*DATA_W +: DATA_W];
        else if (state == ST_MEM_ACC)
            mem_wdata = imm_r;
    end

    always_comb begin
        state_nx   = state;
        seq_start  = 1'b0;
        seq_base   = '0;
        seq_count  = '0;
        seq_dir_we = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid)
                    state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                if (op_r == OP_READ || op_r == OP_WRITE) begin
                    seq_start  = 1'b1;
                    seq_base   = addr_r;
                    seq_count  = CNT_W'(1);
                    seq_dir_we = (op_r == OP_WRITE);
                    state_nx   = ST_MEM_ACC;
                end else if (is_arith(op_r)) begin
                    seq_start = 1'b1;
                    seq_base  = A_BASE;
                    seq_count = CNT_W'(WORDS);
                    state_nx  = ST_LOAD_A;
                end else begin
                    err      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_MEM_ACC: begin
                if (word_end)
                    state_nx = ST_FINISH;
            end
            ST_LOAD_A: begin
                if (word_end) begin
                    seq_start = 1'b1;
                    seq_base  = B_BASE;
                    seq_count = CNT_W'(WORDS);
                    state_nx  = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (word_end)
                    state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_rise) begin
                    seq_start  = 1'b1;
                    seq_base   = C_BASE;
                    seq_count  = is_det(op_r) ? CNT_W'(1) : CNT_W'(WORDS);
                    seq_dir_we = 1'b1;
                    state_nx   = ST_STORE_C;
                end
            end
            ST_STORE_C: begin
                if (word_end)
                    state_nx = ST_FINISH;
            end
            ST_FINISH: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_r       <= '0;
            addr_r     <= '0;
            imm_r      <= '0;
            rd_r       <= '0;
            a_buf      <= '0;
            b_buf      <= '0;
            alu_done_q <= 1'b0;
        end else begin
            state      <= state_nx;
            alu_done_q <= alu_done;
            if (state == ST_IDLE && instr_valid) begin
                op_r   <= instr[OP_LSB +: OP_W];
                addr_r <= instr[ADDR_LSB +: ADDR_W];
                imm_r  <= instr[DATA_LSB +: DATA_W];
            end
            if (state == ST_MEM_ACC && word_valid && op_r == OP_READ)
                rd_r <= mem_rdata;
            // Word k lands at bits [k*DATA_W +: DATA_W]; bits past MAT_BITS are dropped.
            if (state == ST_LOAD_A && word_valid) begin
                for (int b = 0; b < MAT_BITS; b++)
                    if (b / DATA_W == int'(seq_idx))
                        a_buf[b] <= mem_rdata[b % DATA_W];
            end
            if (state == ST_LOAD_B && word_valid) begin
                for (int b = 0; b < MAT_BITS; b++)
                    if (b / DATA_W == int'(seq_idx))
                        b_buf[b] <= mem_rdata[b % DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_EXEC && alu_rise)
            c_buf <= mat_c;
    end

endmodule
